// File: rtl/udma_l2_wr_arbiter.sv
// Shares the uDMA L2 write port between N_CH RX channels: class priority, round-robin within
// a class, lane/byte-enable formatting and a one-entry output register held until grant.
module udma_l2_wr_arbiter #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   localparam int unsigned ID_W  = $clog2(N_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_CH-1:0]          cfg_hi_prio_i,
   input  logic [N_CH-1:0]          ch_valid_i,
   output logic [N_CH-1:0]          ch_ready_o,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
   input  logic [N_CH*DATA_W-1:0]   ch_data_i,
   input  logic [N_CH*2-1:0]        ch_size_i,
   output logic                     l2_req_o,
   input  logic                     l2_gnt_i,
   output logic [ADDR_W-1:0]        l2_addr_o,
   output logic [DATA_W-1:0]        l2_wdata_o,
   output logic [3:0]               l2_be_o,
   output logic [ID_W-1:0]          l2_ch_id_o,
   output logic                     err_o,
   output logic [ID_W-1:0]          err_ch_o
);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   hi_ptr_q, hi_ptr_d, lo_ptr_q, lo_ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              err_q, err_d;
   logic [ID_W-1:0]   err_ch_q, err_ch_d;

   logic [N_CH-1:0]   hi_valid, lo_valid, cand;
   logic [ID_W-1:0]   ptr, idx, win, win_next;
   logic              use_hi, any_valid, found;
   logic              gnt_fire, slot_free, accept, legal;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data, fmt_wdata;
   logic [1:0]        sel_size;
   logic [3:0]        fmt_be;

   assign l2_req_o  = (state_q == StFull);
   assign gnt_fire  = l2_req_o & l2_gnt_i;
   assign slot_free = (state_q == StEmpty) | gnt_fire;

   // High class pre-empts the low class; scan starts at the active class's pointer.
   always_comb begin
      hi_valid  = ch_valid_i & cfg_hi_prio_i;
      lo_valid  = ch_valid_i & ~cfg_hi_prio_i;
      use_hi    = |hi_valid;
      any_valid = |ch_valid_i;
      cand      = use_hi ? hi_valid : lo_valid;
      ptr       = use_hi ? hi_ptr_q : lo_ptr_q;
      win       = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = ID_W'((32'(ptr) + i) % N_CH);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign win_next   = ID_W'((32'(win) + 1) % N_CH);
   assign accept     = any_valid & slot_free & ~rst_i;
   assign ch_ready_o = accept ? ({{(N_CH-1){1'b0}}, 1'b1} << win) : '0;

   assign sel_addr = ch_addr_i[win*ADDR_W +: ADDR_W];
   assign sel_data = ch_data_i[win*DATA_W +: DATA_W];
   assign sel_size = ch_size_i[win*2 +: 2];

   always_comb begin
      legal     = 1'b0;
      fmt_be    = 4'h0;
      fmt_wdata = sel_data;
      case (sel_size)
         2'd0: begin
            legal     = 1'b1;
            fmt_be    = 4'b0001 << sel_addr[1:0];
            fmt_wdata = {4{sel_data[7:0]}};
         end
         2'd1: begin
            legal     = ~sel_addr[0];
            fmt_be    = 4'b0011 << sel_addr[1:0];
            fmt_wdata = {2{sel_data[15:0]}};
         end
         2'd2: begin
            legal     = (sel_addr[1:0] == 2'b00);
            fmt_be    = 4'hF;
            fmt_wdata = sel_data;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      hi_ptr_d = hi_ptr_q;
      lo_ptr_d = lo_ptr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      id_d     = id_q;
      err_d    = 1'b0;
      err_ch_d = err_ch_q;
      if (accept) begin
         if (use_hi) hi_ptr_d = win_next;
         else        lo_ptr_d = win_next;
         if (legal) begin
            state_d = StFull;
            addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
            wdata_d = fmt_wdata;
            be_d    = fmt_be;
            id_d    = win;
         end else begin
            // Error transfers are consumed but never written; the slot is free by construction.
            state_d  = StEmpty;
            err_d    = 1'b1;
            err_ch_d = win;
         end
      end else if (gnt_fire) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StEmpty;
         hi_ptr_q <= '0;
         lo_ptr_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         id_q     <= '0;
         err_q    <= 1'b0;
         err_ch_q <= '0;
      end else begin
         state_q  <= state_d;
         hi_ptr_q <= hi_ptr_d;
         lo_ptr_q <= lo_ptr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         id_q     <= id_d;
         err_q    <= err_d;
         err_ch_q <= err_ch_d;
      end
   end

   assign l2_addr_o  = addr_q;
   assign l2_wdata_o = wdata_q;
   assign l2_be_o    = be_q;
   assign l2_ch_id_o = id_q;
   assign err_o      = err_q;
   assign err_ch_o   = err_ch_q;

endmodule

// File: tb/tb_udma_l2_wr_arbiter.sv
// Scoreboard bench for udma_l2_wr_arbiter: directed phases push expected writes/errors,
// a negedge monitor pops and compares on every L2 handshake and every error pulse.
module tb_udma_l2_wr_arbiter;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [3:0]   cfg_hi_prio;
   logic [3:0]   ch_valid;
   logic [3:0]   ch_ready;
   logic [127:0] ch_addr;
   logic [127:0] ch_data;
   logic [7:0]   ch_size;
   logic         l2_req;
   logic         l2_gnt;
   logic [31:0]  l2_addr;
   logic [31:0]  l2_wdata;
   logic [3:0]   l2_be;
   logic [1:0]   l2_ch_id;
   logic         err;
   logic [1:0]   err_ch;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   exp_t       wq[$];
   int         eq[$];
   exp_t       mon_e;
   int         mon_c;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   udma_l2_wr_arbiter #(.N_CH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .cfg_hi_prio_i (cfg_hi_prio),
      .ch_valid_i    (ch_valid),
      .ch_ready_o    (ch_ready),
      .ch_addr_i     (ch_addr),
      .ch_data_i     (ch_data),
      .ch_size_i     (ch_size),
      .l2_req_o      (l2_req),
      .l2_gnt_i      (l2_gnt),
      .l2_addr_o     (l2_addr),
      .l2_wdata_o    (l2_wdata),
      .l2_be_o       (l2_be),
      .l2_ch_id_o    (l2_ch_id),
      .err_o         (err),
      .err_ch_o      (err_ch)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic set_ch(input int c, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s);
      ch_addr[c*32 +: 32] = a;
      ch_data[c*32 +: 32] = d;
      ch_size[c*2 +: 2]   = s;
   endtask

   task automatic push_w(input logic [1:0] id, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      exp_t e;
      e.id = id; e.addr = a; e.data = d; e.be = be;
      wq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string nm, input logic [3:0] exp_ready);
      @(negedge clk);
      chk(nm, 32'(ch_ready), 32'(exp_ready));
      tick();
   endtask

   // Monitor: a handshake seen at the negedge completes at the following posedge.
   always @(negedge clk) begin
      if (!rst_i && l2_req && l2_gnt) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected actual=ch%0d addr=%h required=none", l2_ch_id, l2_addr);
         end else begin
            mon_e = wq.pop_front();
            chk("wr_id", 32'(l2_ch_id), 32'(mon_e.id));
            chk("wr_addr", l2_addr, mon_e.addr);
            chk("wr_wdata", l2_wdata, mon_e.data);
            chk("wr_be", 32'(l2_be), 32'(mon_e.be));
         end
      end
      if (!rst_i && err) begin
         if (eq.size() == 0) begin
            checks++; errors++;
            $display("FAIL err_unexpected actual=ch%0d required=none", err_ch);
         end else begin
            mon_c = eq.pop_front();
            chk("err_ch", 32'(err_ch), 32'(mon_c));
         end
      end
   end

   initial begin
      rst_i = 1'b1; l2_gnt = 1'b0; cfg_hi_prio = 4'h0; ch_valid = 4'h0;
      ch_addr = '0; ch_data = '0; ch_size = '0;
      for (int c = 0; c < 4; c++) set_ch(c, 32'h4000 + 32'(c) * 32'h10, 32'h1111_1111 * 32'(c + 1), 2'd2);

      // Reset state; ready must stay low during reset even with requests pending.
      repeat (2) tick();
      ch_valid = 4'hF;
      @(negedge clk);
      chk("rst_ready", 32'(ch_ready), 32'h0);
      chk("rst_req", 32'(l2_req), 32'h0);
      chk("rst_addr", l2_addr, 32'h0);
      chk("rst_wdata", l2_wdata, 32'h0);
      chk("rst_be", 32'(l2_be), 32'h0);
      chk("rst_id", 32'(l2_ch_id), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_err_ch", 32'(err_ch), 32'h0);
      tick();

      // Round-robin, low class, grant tied high: 0,1,2,3,0.
      rst_i = 1'b0; l2_gnt = 1'b1;
      for (int k = 0; k < 5; k++)
         push_w(2'(k % 4), 32'h4000 + 32'(k % 4) * 32'h10, 32'h1111_1111 * 32'(k % 4 + 1), 4'hF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rr_ready", 32'(ch_ready), 32'(1) << (k % 4));
         if (k > 0) chk("rr_req_high", 32'(l2_req), 32'h1);
         tick();
      end
      ch_valid = 4'h0;
      @(negedge clk);
      chk("rr_req_hold", 32'(l2_req), 32'h1);
      tick(); tick();

      // Priority: ch2 high wins every cycle; low class then resumes from its pointer (1).
      cfg_hi_prio = 4'b0100; ch_valid = 4'hF;
      push_w(2'd2, 32'h4020, 32'h3333_3333, 4'hF);
      push_w(2'd2, 32'h4020, 32'h3333_3333, 4'hF);
      push_w(2'd2, 32'h4020, 32'h3333_3333, 4'hF);
      push_w(2'd1, 32'h4010, 32'h2222_2222, 4'hF);
      push_w(2'd3, 32'h4030, 32'h4444_4444, 4'hF);
      push_w(2'd0, 32'h4000, 32'h1111_1111, 4'hF);
      step("prio_hi", 4'b0100);
      step("prio_hi", 4'b0100);
      step("prio_hi", 4'b0100);
      ch_valid = 4'b1011;
      step("prio_lo_resume", 4'b0010);
      step("prio_lo_resume", 4'b1000);
      step("prio_lo_resume", 4'b0001);
      ch_valid = 4'h0; cfg_hi_prio = 4'h0;
      tick(); tick();

      // Lane formatting.
      set_ch(0, 32'h1003, 32'h0000_00A5, 2'd0);
      set_ch(1, 32'h2002, 32'h0000_BEEF, 2'd1);
      set_ch(3, 32'h3000, 32'h1234_5678, 2'd2);
      push_w(2'd0, 32'h1000, 32'hA5A5_A5A5, 4'b1000);
      push_w(2'd1, 32'h2000, 32'hBEEF_BEEF, 4'b1100);
      push_w(2'd3, 32'h3000, 32'h1234_5678, 4'b1111);
      ch_valid = 4'b0001; step("lane_byte_ready", 4'b0001);
      ch_valid = 4'b0010; step("lane_half_ready", 4'b0010);
      ch_valid = 4'b1000; step("lane_word_ready", 4'b1000);

      // Misaligned half on ch3, then reserved size on ch1: consumed, two error pulses.
      set_ch(3, 32'h2001, 32'h0000_BEEF, 2'd1);
      set_ch(1, 32'h0000, 32'h0000_0077, 2'd3);
      eq.push_back(3);
      eq.push_back(1);
      ch_valid = 4'b1000; step("mis_ready", 4'b1000);
      ch_valid = 4'b0010;
      @(negedge clk);
      chk("mis_no_req", 32'(l2_req), 32'h0);
      chk("size3_ready", 32'(ch_ready), 32'h2);
      tick();
      ch_valid = 4'h0;
      @(negedge clk);
      chk("size3_no_req", 32'(l2_req), 32'h0);
      tick();
      @(negedge clk);
      chk("err_pulse_end", 32'(err), 32'h0);
      chk("err_ch_hold", 32'(err_ch), 32'h1);
      tick();

      // Grant back-pressure: payload frozen, ready low; release reloads with no bubble.
      l2_gnt = 1'b0;
      set_ch(1, 32'h5000, 32'hCAFE_F00D, 2'd2);
      push_w(2'd1, 32'h5000, 32'hCAFE_F00D, 4'hF);
      ch_valid = 4'b0010; step("bp_accept", 4'b0010);
      set_ch(1, 32'h5004, 32'h0BAD_BEEF, 2'd2);
      push_w(2'd1, 32'h5004, 32'h0BAD_BEEF, 4'hF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_ready_low", 32'(ch_ready), 32'h0);
         chk("bp_req", 32'(l2_req), 32'h1);
         chk("bp_addr", l2_addr, 32'h5000);
         chk("bp_wdata", l2_wdata, 32'hCAFE_F00D);
         tick();
      end
      l2_gnt = 1'b1;
      step("bp_release_ready", 4'b0010);
      ch_valid = 4'h0;
      @(negedge clk);
      chk("bp_no_bubble", 32'(l2_req), 32'h1);
      chk("bp_next_addr", l2_addr, 32'h5004);
      tick();
      l2_gnt = 1'b0;

      // Reset while FULL: request dropped, pointers cleared (low pointer was 3 before).
      set_ch(2, 32'h6000, 32'h0000_0066, 2'd2);
      ch_valid = 4'b0100; step("pre_rst_accept", 4'b0100);
      ch_valid = 4'h0; rst_i = 1'b1;
      tick();
      rst_i = 1'b0; ch_valid = 4'b1010; l2_gnt = 1'b1;
      push_w(2'd1, 32'h5004, 32'h0BAD_BEEF, 4'hF);
      @(negedge clk);
      chk("rst_mid_req", 32'(l2_req), 32'h0);
      chk("rst_first_ready", 32'(ch_ready), 32'h2);
      tick();
      ch_valid = 4'h0;
      repeat (3) tick();
      l2_gnt = 1'b0;
      tick();

      chk("wr_queue_drained", 32'(wq.size()), 32'h0);
      chk("err_queue_drained", 32'(eq.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
